mux_16x1_rr_arbiter: RTL and testbench
======================================

// Module: mux_16x1_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for the shared 16-bit, 16-source mux_16x1 datapath.
//   Takes 16 requesters, picks one winner, and drives the mux select s[3:0] for it.
//   Holds each grant until the downstream consumer accepts the word (valid/ready).
//   Placed between the requesting units and the mux_16x1 instance feeding the shared bus.
// PARAMETERS
//   N_REQ      16  number of requesters; fixed by mux width, not overridable
//   SEL_W       4  select width, log2(N_REQ)
//   MAX_BURST   4  max consecutive transfers per grant (used only with ARB_BURST_EN)
// PORTS
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req        in   16     req[i]=1: source i has a word on mux input a<i>; held until ack[i]
//   out_ready  in   1      downstream accepts the bus word this cycle
//   sel        out  4      registered mux select, drives mux_16x1.s
//   gnt        out  16     registered one-hot grant, gnt[sel]=1 while out_valid
//   out_valid  out  1      registered; the bus word (mux y) is valid
//   ack        out  16     combinational: gnt & {16{out_valid & out_ready}}
//   busy       out  1      registered; equals (state==GRANT)
// BEHAVIOUR
//   Reset (async, rst_n=0): sel=0, gnt=0, out_valid=0, busy=0, state=IDLE, ptr=15, bcnt=0. Outputs clear immediately and stay clear until the first clk edge after rst_n rises.
//   ptr = index of the last winner. Search order: ptr+1, ptr+2, ..., wrapping 15->0.
//   FSM IDLE: if |req, register winner w: sel=w, gnt=1<<w, out_valid=1, state->GRANT.
//     Latency is 1 cycle from req sampled to out_valid.
//   FSM GRANT: out_valid=1 and sel is stable.
//     Handshake = out_valid & out_ready. On that edge: ptr<=sel.
//     Re-arbitrate on the same edge over req & ~gnt; the current winner is masked for that one edge.
//     If a winner exists, load it, stay in GRANT; back-to-back transfers have no bubble.
//     If no winner exists, clear gnt/out_valid and go to IDLE.
//   No handshake: hold sel/gnt/out_valid unchanged. Other requests are ignored; no preemption.
//   Protocol fault: req[sel]=0 in GRANT without a handshake.
//     Clear gnt/out_valid next edge, state->IDLE, ptr unchanged.
//   Wrap: with ptr=15, the search starts at 0. All 16 requesting gives order 0,1,...,15,0.
//   A single requester that keeps req high is re-granted after one IDLE cycle.
//     This comes from the winner mask.
//   Reset mid-transfer: the transfer is abandoned and no ack is issued after reset.
// CONFIGURATION
//   Macro ARB_BURST_EN.
//   Defined: 2-bit bcnt counts handshakes for the current winner.
//     On a handshake with req[sel] still 1 and bcnt<MAX_BURST-1: keep the grant and bcnt++.
//       The winner is not masked in this case.
//     Otherwise: rotate as in BEHAVIOUR and clear bcnt. bcnt clears on every new grant.
//   Undefined: bcnt is not instantiated. The grant rotates after every handshake (burst length 1).
// STRUCTURE
//   Shared package arb_pkg holds:
//     N_REQ and SEL_W;
//     FSM encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
//     a function onehot_to_idx.
//   Sub-module rr_pick, purely combinational:
//     inputs req[15:0], ptr[3:0], mask[15:0];
//     outputs found, idx[3:0].
//     Double-width rotate-and-priority-encode.
//   Top level holds the FSM, ptr/bcnt registers and the output registers.
// TESTING
//   Arbiter drives a real mux_16x1 instance. Source a<i>=16'hA000+i. Bench checks y==16'hA000+sel whenever out_valid.
//   1. Reset: rst_n=0 mid-GRANT -> out_valid=0, gnt=0, sel=0 immediately. First grant after release with req=16'h0001 is sel=0.
//   2. Single req: req=16'h0020, out_ready=1 ->
//      out_valid at +1 cycle, sel=5, ack[5] that cycle;
//      next cycle IDLE; regranted at +3.
//   3. Round-robin: req=16'hFFFF held, out_ready=1, ptr=15 after reset ->
//      sel=0,1,...,15,0 on consecutive cycles, no bubbles, y=A000..A00F.
//   4. Backpressure: req=16'h0104, out_ready=0 for 5 cycles ->
//      sel=2 held, gnt=16'h0004 stable;
//      ready=1 -> ack[2], then sel=8 on the next cycle.
//   5. Fault: grant to 3, drop req[3] without ready -> IDLE next edge, ptr unchanged.
//      req=16'h0018 -> sel=3 again.
//   6. ARB_BURST_EN: req=16'h0003 held, out_ready=1 ->
//      sel=0 x4, then 1 x4, then 0; with the macro undefined -> 0,1,0,1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, FSM encoding and index helper for the 16-source round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ     = 16;
  localparam int unsigned SEL_W     = 4;
  localparam int unsigned MAX_BURST = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StGrant = ST_GRANT
  } arb_state_e;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx |= SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_16x1.sv
// 16-to-1 mux of 16-bit words, steered by the arbiter select.
module mux_16x1 (
  input  logic [15:0][15:0] a_i,
  input  logic [3:0]        s_i,
  output logic [15:0]       y_o
);

  assign y_o = a_i[s_i];

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) searching from ptr+1 upward.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_REQ-1:0]   cand;
  logic [SEL_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   first;

  always_comb begin
    cand  = req_i & mask_i;
    start = ptr_i + SEL_W'(1);
    // Bit k of rot corresponds to requester (start + k) mod N_REQ.
    dbl   = {cand, cand} >> start;
    rot   = N_REQ'(dbl);
    first = rot & (~rot + N_REQ'(1));
    found_o = |cand;
    idx_o   = start + onehot_to_idx(first);
  end

endmodule

// File: rtl/mux_16x1_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared mux_16x1 bus; grants held until valid/ready.
// Optional ARB_BURST_EN lets a winner keep the grant for up to MAX_BURST transfers.
module mux_16x1_rr_arbiter
  import arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             out_ready_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic             out_valid_o,
  output logic [N_REQ-1:0] ack_o,
  output logic             busy_o
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef ARB_BURST_EN
  logic [1:0]       bcnt_q, bcnt_d;
`endif

  logic             found;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  logic             keep;

  // During a grant the current winner is masked and the search starts just past it.
  assign pick_ptr  = (state_q == StGrant) ? sel_q : ptr_q;
  assign pick_mask = (state_q == StGrant) ? ~gnt_q : '1;

  rr_pick u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (pick_ptr),
    .mask_i  (pick_mask),
    .found_o (found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    keep    = 1'b0;
`ifdef ARB_BURST_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          sel_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          state_d         = StGrant;
`ifdef ARB_BURST_EN
          bcnt_d          = '0;
`endif
        end
      end
      StGrant: begin
        if (out_ready_i) begin
          ptr_d = sel_q;
`ifdef ARB_BURST_EN
          if (req_i[sel_q] && (bcnt_q < 2'(MAX_BURST - 1))) begin
            keep   = 1'b1;
            bcnt_d = bcnt_q + 2'd1;
          end else begin
            bcnt_d = '0;
          end
`endif
          if (!keep) begin
            if (found) begin
              sel_d           = pick_idx;
              gnt_d           = '0;
              gnt_d[pick_idx] = 1'b1;
            end else begin
              gnt_d   = '0;
              state_d = StIdle;
            end
          end
        end else if (!req_i[sel_q]) begin
          // Requester withdrew before its word was taken: abandon without moving ptr.
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sel_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= SEL_W'(N_REQ - 1);
`ifdef ARB_BURST_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
`ifdef ARB_BURST_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign sel_o       = sel_q;
  assign gnt_o       = gnt_q;
  assign out_valid_o = (state_q == StGrant);
  assign busy_o      = (state_q == StGrant);
  assign ack_o       = gnt_q & {N_REQ{out_valid_o & out_ready_i}};

endmodule

// File: tb/tb_mux_16x1_rr_arbiter.sv
// Directed self-checking bench: arbiter driving a mux_16x1 with sources 16'hA000+i.
module tb_mux_16x1_rr_arbiter;

  logic             clk;
  logic             rst_n;
  logic [15:0]      req;
  logic             out_ready;
  logic [3:0]       sel;
  logic [15:0]      gnt;
  logic             out_valid;
  logic [15:0]      ack;
  logic             busy;
  logic [15:0][15:0] mux_a;
  logic [15:0]      y;

  int total;
  int bad;

  mux_16x1_rr_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .out_ready_i (out_ready),
    .sel_o       (sel),
    .gnt_o       (gnt),
    .out_valid_o (out_valid),
    .ack_o       (ack),
    .busy_o      (busy)
  );

  mux_16x1 u_mux (
    .a_i (mux_a),
    .s_i (sel),
    .y_o (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect an active grant to source idx, including the bus word it puts on y.
  task automatic check_grant(input string tag, input int idx);
    logic [15:0] oh;
    oh = 16'h0001 << idx;
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sel"}, 32'(sel), 32'(idx));
    check({tag, ".gnt"}, 32'(gnt), 32'(oh));
    check({tag, ".y"}, 32'(y), 32'(16'hA000 + 16'(idx)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) mux_a[i] = 16'hA000 + 16'(i);
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    #3;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.sel", 32'(sel), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);

    // 1. Reset asserted mid-GRANT clears outputs at once.
    #4;
    rst_n = 1'b1;
    req   = 16'h0002;
    tick();
    check_grant("t1.pre", 1);
    check("t1.pre.busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1.async.valid", 32'(out_valid), 32'd0);
    check("t1.async.gnt", 32'(gnt), 32'd0);
    check("t1.async.sel", 32'(sel), 32'd0);
    check("t1.async.busy", 32'(busy), 32'd0);
    req       = 16'h0001;
    out_ready = 1'b1;
    check("t1.async.ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    #1;
    check("t1.released.valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    tick();
    check_grant("t1.first", 0);

    // 2. Single requester: grant, ack, one IDLE cycle, regrant.
    do_reset();
    req       = 16'h0020;
    out_ready = 1'b1;
    tick();
    check_grant("t2.g1", 5);
    check("t2.g1.ack", 32'(ack), 32'h0020);
    tick();
    check("t2.idle.valid", 32'(out_valid), 32'd0);
    check("t2.idle.busy", 32'(busy), 32'd0);
    check("t2.idle.ack", 32'(ack), 32'd0);
    tick();
    check_grant("t2.g2", 5);

    // 3. All requesting: 0..15 then wrap to 0, no bubbles.
    do_reset();
    req       = 16'hFFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      check_grant($sformatf("t3.rr%0d", i), i % 16);
    end

    // 4. Backpressure holds the grant; release moves to the next requester.
    do_reset();
    req       = 16'h0104;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_grant($sformatf("t4.hold%0d", i), 2);
      check($sformatf("t4.hold%0d.ack", i), 32'(ack), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t4.ack", 32'(ack), 32'h0004);
    tick();
    check_grant("t4.next", 8);

    // 5. Protocol fault: requester drops without a handshake.
    do_reset();
    req = 16'h0008;
    tick();
    check_grant("t5.g", 3);
    req = 16'h0000;
    tick();
    check("t5.fault.valid", 32'(out_valid), 32'd0);
    check("t5.fault.gnt", 32'(gnt), 32'd0);
    check("t5.fault.busy", 32'(busy), 32'd0);
    req = 16'h0018;
    tick();
    check_grant("t5.regrant", 3);

    // 6. Two requesters held: burst behaviour depends on the build.
    do_reset();
    req       = 16'h0003;
    out_ready = 1'b1;
`ifdef ARB_BURST_EN
    for (int i = 0; i < 9; i++) begin
      tick();
      check_grant($sformatf("t6.burst%0d", i), (i / 4) % 2);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      check_grant($sformatf("t6.alt%0d", i), i % 2);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
